// File: rtl/lcd_pkg.sv
// Shared types and image geometry for the LCD host driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    REFLASH  = 3'd1,
    ZOOM_FIT = 3'd2,
    RIGHT    = 3'd3,
    LEFT     = 3'd4,
    UP       = 3'd5,
    DOWN     = 3'd6,
    ILLEGAL  = 3'd7
  } lcd_cmd_e;

  localparam int IMG_W     = 12;
  localparam int IMG_H     = 9;
  localparam int IMG_BYTES = IMG_W * IMG_H;
  localparam int FRAME_PIX = 16;

  localparam logic [6:0] LAST_ADDR = 7'(IMG_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    STREAM = 2'd2,
    WAIT   = 2'd3
  } lcd_state_e;

  function automatic logic is_legal(input logic [2:0] code);
    return code != ILLEGAL;
  endfunction

endpackage

// File: rtl/lcd_host_cmdq.sv
// Command FIFO for lcd_host: CQ_DEPTH entries of 3-bit command codes, head visible combinationally.
module lcd_host_cmdq
  import lcd_pkg::*;
#(
  parameter int CQ_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [2:0] push_data,
  input  logic       pop,
  output logic [2:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(CQ_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(CQ_DEPTH);

  logic [2:0]    mem [CQ_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue only lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_host.sv
// Host-side LCD controller driver: queued commands, LOAD image streaming, frame capture.
// Optional frame pixel sum enabled with `define LCD_HOST_SUM_EN.
module lcd_host
  import lcd_pkg::*;
#(
  parameter int CQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  cq_cmd,
  input  logic        cq_valid,
  output logic        cq_ready,
  output logic        cmd_err,
  output logic [6:0]  img_addr,
  input  logic [7:0]  img_data,
  output logic [2:0]  cmd,
  output logic        cmd_valid,
  output logic [7:0]  datain,
  input  logic        busy,
  input  logic [7:0]  dataout,
  input  logic        output_valid,
  output logic [7:0]  pix_data,
  output logic [3:0]  pix_idx,
  output logic        pix_valid,
  output logic        frame_done,
  output logic [11:0] frame_sum
);

  lcd_state_e state;
  logic       run_q;
  logic       q_push;
  logic       q_pop;
  logic       q_full;
  logic       q_empty;
  logic [2:0] q_head;
  logic [6:0] byte_cnt;
  logic [3:0] pix_cnt;
  logic       capture;
  logic       frame_end;

  // run_q keeps cq_ready low while reset is held and for the release cycle.
  assign cq_ready  = run_q && !q_full;
  assign q_push    = cq_valid && is_legal(cq_cmd) && run_q;
  assign q_pop     = (state == IDLE) && !q_empty && !busy;
  assign capture   = (state == WAIT) && output_valid;
  assign frame_end = (state == WAIT) && !busy;

  lcd_host_cmdq #(
    .CQ_DEPTH (CQ_DEPTH)
  ) u_cmdq (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (cq_cmd),
    .pop       (q_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      run_q      <= 1'b0;
      cmd_err    <= 1'b0;
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      cmd        <= '0;
      datain     <= '0;
      img_addr   <= '0;
      pix_data   <= '0;
      pix_idx    <= '0;
      pix_cnt    <= '0;
      byte_cnt   <= '0;
    end else begin
      run_q      <= 1'b1;
      cmd_err    <= cq_valid && !is_legal(cq_cmd);
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          // img_addr already rests at 0 here, so a LOAD head has byte 0 fetched during ISSUE.
          if (q_pop) begin
            cmd       <= q_head;
            cmd_valid <= 1'b1;
            state     <= ISSUE;
            if (q_head == LOAD) img_addr <= 7'd1;
          end
        end
        ISSUE: begin
          if (cmd == LOAD) begin
            datain   <= img_data;
            byte_cnt <= '0;
            img_addr <= img_addr + 7'd1;
            state    <= STREAM;
          end else begin
            state <= WAIT;
          end
        end
        STREAM: begin
          // Address runs one byte ahead of datain and parks at 0 after the last fetch.
          if (img_addr == LAST_ADDR)  img_addr <= '0;
          else if (img_addr != '0)    img_addr <= img_addr + 7'd1;
          if (byte_cnt == LAST_ADDR) begin
            state <= WAIT;
          end else begin
            datain   <= img_data;
            byte_cnt <= byte_cnt + 7'd1;
          end
        end
        WAIT: begin
          if (capture) begin
            pix_data  <= dataout;
            pix_valid <= 1'b1;
            pix_idx   <= pix_cnt;
            pix_cnt   <= pix_cnt + 4'd1;
          end
          if (frame_end) begin
            frame_done <= 1'b1;
            pix_idx    <= '0;
            pix_cnt    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LCD_HOST_SUM_EN
  logic [11:0] acc;
  logic [11:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (capture) acc_next = acc + 12'(dataout);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc       <= '0;
      frame_sum <= '0;
    end else if (frame_end) begin
      frame_sum <= acc_next;
      acc       <= '0;
    end else begin
      acc <= acc_next;
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_lcd_host.sv
// Self-checking bench for lcd_host with a behavioural LCD controller and synchronous image ROM.
`timescale 1ns/1ps
module tb_lcd_host;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  cq_cmd = 3'd0;
  logic        cq_valid = 1'b0;
  logic        cq_ready;
  logic        cmd_err;
  logic [6:0]  img_addr;
  logic [7:0]  img_data = 8'd0;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic [7:0]  datain;
  logic        busy;
  logic [7:0]  dataout = 8'd0;
  logic        output_valid = 1'b0;
  logic [7:0]  pix_data;
  logic [3:0]  pix_idx;
  logic        pix_valid;
  logic        frame_done;
  logic [11:0] frame_sum;

  int checks = 0;
  int errors = 0;

  lcd_host #(.CQ_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cq_cmd       (cq_cmd),
    .cq_valid     (cq_valid),
    .cq_ready     (cq_ready),
    .cmd_err      (cmd_err),
    .img_addr     (img_addr),
    .img_data     (img_data),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .datain       (datain),
    .busy         (busy),
    .dataout      (dataout),
    .output_valid (output_valid),
    .pix_data     (pix_data),
    .pix_idx      (pix_idx),
    .pix_valid    (pix_valid),
    .frame_done   (frame_done),
    .frame_sum    (frame_sum)
  );

  always #5 clk = ~clk;

  // Synchronous image ROM: data for an address appears one cycle later.
  logic [7:0] rom [108];
  always @(posedge clk) img_data <= rom[img_addr];

  // Controller model and observation, evaluated on the falling edge.
  logic       m_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic       m_load = 1'b0;
  logic       prev_cv = 1'b0;
  int         m_phase = 0;
  int         m_cnt = 0;
  int         m_gap = 0;
  int         fd_cnt = 0;
  int         err_cnt = 0;
  int         viol = 0;
  logic [7:0] recv [108];
  logic [7:0] em_q [$];
  logic [7:0] obs_pix [$];
  logic [3:0] obs_idx [$];
  logic [2:0] iss_q [$];
  logic [11:0] sum_q [$];

  assign busy = m_busy | hold_busy;

  always @(negedge clk) begin
    if (pix_valid) begin
      obs_pix.push_back(pix_data);
      obs_idx.push_back(pix_idx);
    end
    if (frame_done) begin
      fd_cnt++;
      sum_q.push_back(frame_sum);
    end
    if (cmd_err) err_cnt++;
    if (cmd_valid) begin
      iss_q.push_back(cmd);
      if (busy || prev_cv) viol++;
    end
    prev_cv = cmd_valid;
    output_valid = 1'b0;
    if (!reset) begin
      m_busy  = 1'b0;
      m_phase = 0;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
             m_busy  = 1'b1;
             m_cnt   = 0;
             m_load  = (cmd == 3'd0);
             m_phase = m_load ? 1 : 2;
           end
        1: begin
             recv[m_cnt] = datain;
             m_cnt++;
             if (m_cnt == 108) begin
               m_cnt   = 0;
               m_phase = 2;
             end
           end
        2: if ($urandom_range(0, 2) != 0) begin
             if (m_load) dataout = recv[(1 + 2 * (m_cnt / 4)) * 12 + 1 + 3 * (m_cnt % 4)];
             else        dataout = 8'($urandom);
             em_q.push_back(dataout);
             output_valid = 1'b1;
             m_cnt++;
             if (m_cnt == 16) begin
               m_phase = 3;
               m_gap   = $urandom_range(0, 2);
             end
           end
        default: if (m_gap == 0) begin
                   m_busy  = 1'b0;
                   m_phase = 0;
                 end else begin
                   m_gap--;
                 end
      endcase
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout reached required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] c);
    cq_cmd   = c;
    cq_valid = 1'b1;
    tick();
    cq_valid = 1'b0;
  endtask

  task automatic wait_issue(output int lat);
    lat = 0;
    while (cmd_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int i = 0; i < budget && fd_cnt < target; i++) tick();
    repeat (4) tick();
  endtask

  task automatic clear_obs();
    em_q.delete();
    obs_pix.delete();
    obs_idx.delete();
    iss_q.delete();
    sum_q.delete();
  endtask

  // Pixel k of the returned frame samples image row 1+2*(k/4), column 1+3*(k%4).
  function automatic logic [7:0] rom_pix(input int k);
    return rom[(1 + 2 * (k / 4)) * 12 + 1 + 3 * (k % 4)];
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cq_ready, cmd_err, cmd_valid, pix_valid, frame_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=00000",
               {cq_ready, cmd_err, cmd_valid, pix_valid, frame_done});
    end
    checks++;
    if ({cmd, datain, img_addr, pix_data, pix_idx, frame_sum} !== '0) begin
      errors++;
      $display("FAIL reset_data cmd=%0d datain=%0d img_addr=%0d pix_data=%0d pix_idx=%0d frame_sum=%0d required=all 0",
               cmd, datain, img_addr, pix_data, pix_idx, frame_sum);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (cq_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b required=1", cq_ready);
    end
  endtask

  task automatic test_load_identity();
    int exp_tab [16];
    int lat, mism, base, exp_sum;
    exp_tab = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
    for (int i = 0; i < 108; i++) rom[i] = 8'(i);
    clear_obs();
    base = fd_cnt;
    push(3'd0);
    wait_issue(lat);
    checks++;
    if (lat != 1) begin
      errors++;
      $display("FAIL load_latency got=%0d required=1", lat);
    end
    mism = 0;
    for (int k = 0; k < 108; k++) begin
      tick();
      if (datain !== 8'(k)) mism++;
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL load_stream mismatches=%0d required=0", mism);
    end
    wait_frames(base + 1, 500);
    checks++;
    if (fd_cnt != base + 1) begin
      errors++;
      $display("FAIL load_frame_done got=%0d required=%0d", fd_cnt - base, 1);
    end
    mism = 0;
    for (int k = 0; k < 16; k++)
      if (k >= obs_pix.size() || obs_pix[k] !== 8'(exp_tab[k]) || obs_idx[k] !== 4'(k)) mism++;
    checks++;
    if (mism != 0 || obs_pix.size() != 16) begin
      errors++;
      $display("FAIL load_pixels bad=%0d count=%0d required=0 bad, 16 pixels", mism, obs_pix.size());
    end
`ifdef LCD_HOST_SUM_EN
    exp_sum = 856;
`else
    exp_sum = 0;
`endif
    checks++;
    if (sum_q.size() != 1 || sum_q[0] !== 12'(exp_sum)) begin
      errors++;
      $display("FAIL load_sum got=%0d entries=%0d required=%0d",
               (sum_q.size() > 0) ? int'(sum_q[0]) : -1, sum_q.size(), exp_sum);
    end
  endtask

  task automatic test_load_random();
    int lat, mism, base, exp_sum;
    for (int i = 0; i < 108; i++) rom[i] = 8'($urandom);
    clear_obs();
    base = fd_cnt;
    push(3'd0);
    wait_issue(lat);
    mism = 0;
    for (int k = 0; k < 108; k++) begin
      tick();
      if (datain !== rom[k]) mism++;
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL rand_stream mismatches=%0d required=0", mism);
    end
    wait_frames(base + 1, 500);
    mism = 0;
    exp_sum = 0;
    for (int k = 0; k < 16; k++) begin
      exp_sum += rom_pix(k);
      if (k >= obs_pix.size() || obs_pix[k] !== rom_pix(k) || obs_idx[k] !== 4'(k)) mism++;
    end
`ifndef LCD_HOST_SUM_EN
    exp_sum = 0;
`endif
    checks++;
    if (mism != 0 || obs_pix.size() != 16) begin
      errors++;
      $display("FAIL rand_pixels bad=%0d count=%0d required=0 bad, 16 pixels", mism, obs_pix.size());
    end
    checks++;
    if (sum_q.size() != 1 || sum_q[0] !== 12'(exp_sum)) begin
      errors++;
      $display("FAIL rand_sum got=%0d required=%0d",
               (sum_q.size() > 0) ? int'(sum_q[0]) : -1, exp_sum & 12'hfff);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_c [4];
    int mism, base;
    exp_c = '{3'd0, 3'd2, 3'd3, 3'd1};
    clear_obs();
    base = fd_cnt;
    for (int i = 0; i < 4; i++) push(exp_c[i]);
    wait_frames(base + 4, 3000);
    checks++;
    if (fd_cnt != base + 4) begin
      errors++;
      $display("FAIL b2b_frames got=%0d required=4", fd_cnt - base);
    end
    mism = 0;
    for (int i = 0; i < 4; i++)
      if (i >= iss_q.size() || iss_q[i] !== exp_c[i]) mism++;
    checks++;
    if (mism != 0 || iss_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_issue_order bad=%0d issued=%0d required=0 bad, 4 issued", mism, iss_q.size());
    end
    mism = 0;
    for (int k = 0; k < 64; k++) begin
      if (k >= obs_pix.size() || k >= em_q.size() || obs_pix[k] !== em_q[k] || obs_idx[k] !== 4'(k % 16))
        mism++;
      else if (k < 16 && obs_pix[k] !== rom_pix(k))
        mism++;
    end
    checks++;
    if (mism != 0 || obs_pix.size() != 64) begin
      errors++;
      $display("FAIL b2b_pixels bad=%0d count=%0d required=0 bad, 64 pixels", mism, obs_pix.size());
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL b2b_protocol violations=%0d required=0", viol);
    end
  endtask

  task automatic test_queue_full();
    logic [2:0] cmds [6];
    int mism, base;
    clear_obs();
    base = fd_cnt;
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) cmds[i] = 3'($urandom_range(0, 6));
    for (int i = 0; i < 4; i++) push(cmds[i]);
    checks++;
    if (cq_ready !== 1'b0) begin
      errors++;
      $display("FAIL qfull_ready got=%b required=0", cq_ready);
    end
    push(cmds[4]);
    push(cmds[5]);
    repeat (5) tick();
    checks++;
    if (iss_q.size() != 0) begin
      errors++;
      $display("FAIL qfull_held_issue got=%0d required=0", iss_q.size());
    end
    hold_busy = 1'b0;
    wait_frames(base + 4, 3000);
    repeat (40) tick();
    mism = 0;
    for (int i = 0; i < 4; i++)
      if (i >= iss_q.size() || iss_q[i] !== cmds[i]) mism++;
    checks++;
    if (mism != 0 || iss_q.size() != 4) begin
      errors++;
      $display("FAIL qfull_issued bad=%0d issued=%0d required=0 bad, 4 issued", mism, iss_q.size());
    end
  endtask

  task automatic test_illegal();
    logic [2:0] cmds [4];
    int mism, base, ebase;
    clear_obs();
    base  = fd_cnt;
    ebase = err_cnt;
    hold_busy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) cmds[i] = 3'($urandom_range(1, 6));
    for (int i = 0; i < 3; i++) push(cmds[i]);
    push(3'd7);
    checks++;
    if (cmd_err !== 1'b1 || cq_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pulse cmd_err=%b cq_ready=%b required=1 1", cmd_err, cq_ready);
    end
    push(cmds[3]);
    checks++;
    if (cmd_err !== 1'b0 || cq_ready !== 1'b0 || err_cnt - ebase != 1) begin
      errors++;
      $display("FAIL illegal_after cmd_err=%b cq_ready=%b pulses=%0d required=0 0 1",
               cmd_err, cq_ready, err_cnt - ebase);
    end
    hold_busy = 1'b0;
    wait_frames(base + 4, 3000);
    repeat (40) tick();
    mism = 0;
    for (int i = 0; i < 4; i++)
      if (i >= iss_q.size() || iss_q[i] !== cmds[i]) mism++;
    checks++;
    if (mism != 0 || iss_q.size() != 4) begin
      errors++;
      $display("FAIL illegal_issued bad=%0d issued=%0d required=0 bad, 4 issued", mism, iss_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int lat, mism, base;
    for (int i = 0; i < 108; i++) rom[i] = 8'($urandom);
    clear_obs();
    push(3'd0);
    push(3'd1);
    wait_issue(lat);
    repeat (51) tick();
    checks++;
    if (datain !== rom[50]) begin
      errors++;
      $display("FAIL midrst_byte50 got=%0d required=%0d", datain, rom[50]);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (cmd_valid !== 1'b0 || datain !== 8'd0 || img_addr !== 7'd0 || cq_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_state cmd_valid=%b datain=%0d img_addr=%0d cq_ready=%b required=0 0 0 0",
               cmd_valid, datain, img_addr, cq_ready);
    end
    reset = 1'b1;
    iss_q.delete();
    repeat (30) tick();
    checks++;
    if (iss_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_flush issued=%0d required=0", iss_q.size());
    end
    clear_obs();
    base = fd_cnt;
    push(3'd0);
    wait_issue(lat);
    mism = 0;
    for (int k = 0; k < 108; k++) begin
      tick();
      if (datain !== rom[k]) mism++;
    end
    checks++;
    if (mism != 0) begin
      errors++;
      $display("FAIL midrst_restream mismatches=%0d required=0", mism);
    end
    wait_frames(base + 1, 500);
    mism = 0;
    for (int k = 0; k < 16; k++)
      if (k >= obs_pix.size() || obs_pix[k] !== rom_pix(k) || obs_idx[k] !== 4'(k)) mism++;
    checks++;
    if (mism != 0 || fd_cnt != base + 1) begin
      errors++;
      $display("FAIL midrst_frame bad=%0d frames=%0d required=0 bad, 1 frame", mism, fd_cnt - base);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL final_protocol violations=%0d required=0", viol);
    end
  endtask

  initial begin
    for (int i = 0; i < 108; i++) rom[i] = 8'd0;
    test_reset();
    test_load_identity();
    test_load_random();
    test_back_to_back();
    test_queue_full();
    test_illegal();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_host.md
# lcd_host

Host-side driver for the LCD controller port. Accepts queued display commands, issues them on the cmd/cmd_valid/busy handshake, and streams a 108-byte (12×9) image from a synchronous image ROM for LOAD. Captures the 16-pixel frame returned on dataout/output_valid. Sits between the system sequencer and the LCD controller, and drives every controller input.

## Interface
- CQ_DEPTH, 4: command queue depth; power of 2, minimum 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous reset, active-low: asserted when low, sampled on the rising edge of clk.
- cq_cmd  input  3  command to enqueue. 0 LOAD, 1 REFLASH, 2 ZOOM_FIT, 3 RIGHT, 4 LEFT, 5 UP, 6 DOWN.
- cq_valid  input  1  enqueue request.
- cq_ready  output  1  queue not full.
- cmd_err  output  1  one-cycle pulse when cq_cmd==7 is offered; the code is dropped and not enqueued.
- img_addr  output  7  image ROM address, 0..107.
- img_data  input  8  ROM data; valid 1 cycle after img_addr.
- cmd  output  3  command to the controller.
- cmd_valid  output  1  command strobe to the controller.
- datain  output  8  image byte to the controller.
- busy  input  1  controller busy.
- dataout  input  8  controller pixel.
- output_valid  input  1  controller pixel strobe.
- pix_data  output  8  captured pixel.
- pix_idx  output  4  pixel index within the frame, 0..15.
- pix_valid  output  1  captured pixel strobe.
- frame_done  output  1  one-cycle pulse when busy falls after a command.
- frame_sum  output  12  sum of the last frame's 16 pixels (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, STREAM, WAIT.
- IDLE:
  - When the queue is non-empty and busy==0, pop the head into cmd and go to ISSUE.
  - When the head is LOAD, also drive img_addr=0 in this cycle.
- ISSUE (1 cycle):
  - cmd_valid=1, cmd held.
  - LOAD goes to STREAM; any other command goes to WAIT.
- STREAM:
  - datain is registered and holds byte k during cycle T+1+k, where T is the ISSUE cycle and k=0..107.
  - img_addr is issued one cycle ahead of the byte it fetches.
  - After byte 107, go to WAIT.
  - busy is ignored in STREAM.
- WAIT:
  - Each cycle with output_valid=1: pix_data<=dataout, pix_valid=1, pix_idx then increments. pix_idx wraps 15→0.
  - The first cycle busy==0 is observed: frame_done=1, pix_idx<=0, go to IDLE.
- cmd_valid is never asserted while busy==1, and never in two consecutive cycles.
- cmd and datain hold their last value when not in use.
- Queue behaviour:
  - Simultaneous push and pop is allowed when full; count is unchanged.
  - Push while full (cq_ready==0) is ignored.
  - cmd_err takes priority over the push.
- Reset mid-operation flushes the queue, returns to IDLE and abandons any stream. The controller must be reset in the same cycle.

## Timing
- Reset values:
  - Asserted low: cq_ready, cmd_err, cmd_valid, pix_valid, frame_done.
  - Zero: cmd, datain, img_addr, pix_data, pix_idx, frame_sum.
- Enqueue→cmd_valid: 2 cycles minimum, with an empty queue and busy==0.
- LOAD occupies ISSUE plus 108 STREAM cycles, then WAIT.
- pix_valid follows output_valid by 1 cycle.
- frame_done fires in the cycle after busy is first sampled low in WAIT.
- The next ISSUE is possible in the cycle after frame_done.

## Configuration
- LCD_HOST_SUM_EN defined:
  - A 12-bit accumulator adds each captured pixel, zero-extended, and clears on frame_done.
  - frame_sum registers the final total on frame_done.
- LCD_HOST_SUM_EN undefined: no accumulator; frame_sum is tied to 0.

## Structure
- Package lcd_pkg:
  - Command enum lcd_cmd_e (LOAD..DOWN, value 7 illegal).
  - IMG_W=12, IMG_H=9, IMG_BYTES=108, FRAME_PIX=16.
  - FSM state enum.
- Sub-module lcd_host_cmdq: synchronous CQ_DEPTH×3-bit FIFO with push/pop/full/empty; the illegal-code filter stays in lcd_host.
- The top instantiates one lcd_host_cmdq; everything else is inline.

## Test plan
- Reset: hold reset=0 for 3 cycles → every output is at its reset value, cq_ready=1 after release.
- LOAD then capture: ROM byte i=i; enqueue LOAD → datain 0..107 on consecutive cycles starting the cycle after cmd_valid. Pixels must be 13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94 with pix_idx 0..15. Then one frame_done, and frame_sum=856 when LCD_HOST_SUM_EN is defined, 0 otherwise.
- Back-to-back: enqueue LOAD, ZOOM_FIT, RIGHT, REFLASH → four issues, each only after busy low; 4 frame_done pulses, and no cmd_valid while busy=1.
- Queue full: push 6 commands at CQ_DEPTH=4 while the controller holds busy=1 → cq_ready=0 after 4, the extra pushes are dropped, and exactly 4 commands are issued after release.
- Illegal code: push cq_cmd=7 → cmd_err pulses for 1 cycle, the queue count is unchanged, and nothing is issued.
- Mid-stream reset: assert reset at stream byte 50 → the next cycle is IDLE with an empty queue and cmd_valid=0. A fresh LOAD then restarts at byte 0.
